// File: rtl/load_store_unit_pkg.sv
// Shared load/store unit definitions: FSM encoding, funct3 access-size codes,
// and the rule deciding whether a new access is legal.
package load_store_unit_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    // funct3[1:0] encodes the size (0 byte, 1 half, 2 word) for both loads and stores.
    function automatic logic access_illegal(input logic [2:0] funct3,
                                            input logic       is_store,
                                            input logic [1:0] offset);
        logic bad_f3;
        logic misaligned;
        if (is_store)
            bad_f3 = (funct3 > SW);
        else
            bad_f3 = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        misaligned = ((funct3[1:0] == 2'd1) && offset[0]) ||
                     ((funct3[1:0] == 2'd2) && (offset != 2'd0));
        return bad_f3 || misaligned;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_extend
    import load_store_unit_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    output logic [DWIDTH-1:0] ext_data
);

    logic [7:0]  byte_dat;
    logic [15:0] half_dat;

    always_comb begin
        byte_dat = rdata[{offset, 3'b000} +: 8];
        half_dat = rdata[{offset[1], 4'b0000} +: 16];
        case (funct3)
            LB:      ext_data = {{(DWIDTH-8){byte_dat[7]}}, byte_dat};
            LH:      ext_data = {{(DWIDTH-16){half_dat[15]}}, half_dat};
            LBU:     ext_data = {{(DWIDTH-8){1'b0}}, byte_dat};
            LHU:     ext_data = {{(DWIDTH-16){1'b0}}, half_dat};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory access, byte-lane steering and load extension.
// Latency: load done_o 3 cycles after accept (2 for store) plus any gnt/rvalid wait states.
// Backpressure: stall_o holds the pipeline from accept until DONE; memory side waits on gnt/rvalid indefinitely.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] store_data_i,
    output logic              stall_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DWIDTH-1:0] memory_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i
);

    lsu_state_t        state;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              access, both, illegal_acc, accept;
    logic [3:0]        be_nxt;
    logic [DWIDTH-1:0] wdata_nxt;
    logic [DWIDTH-1:0] ext_data;

    assign both        = valid_i & memren_i & memwren_i;
    assign access      = valid_i & (memren_i ^ memwren_i);
    assign illegal_acc = access & access_illegal(funct3_i, memwren_i, addr_i[1:0]);
    assign accept      = (state == IDLE) & access & ~illegal_acc;

    // Gated with reset so both combinational flags read 0 while reset is held.
    assign err_o   = reset & (state == IDLE) & (both | illegal_acc);
    assign stall_o = (state == REQ) | (state == WAIT) | (reset & accept);

    always_comb begin
        case (funct3_i[1:0])
            2'd0:    be_nxt = 4'b0001 << addr_i[1:0];
            2'd1:    be_nxt = 4'b0011 << addr_i[1:0];
            default: be_nxt = 4'b1111;
        endcase
        case (funct3_i)
            SB:      wdata_nxt = {(DWIDTH/8){store_data_i[7:0]}};
            SH:      wdata_nxt = {(DWIDTH/16){store_data_i[15:0]}};
            SW:      wdata_nxt = store_data_i;
            default: wdata_nxt = store_data_i;
        endcase
    end

    load_extend #(.DWIDTH(DWIDTH)) u_load_extend (
        .rdata    (mem_rdata_i),
        .offset   (off_q),
        .funct3   (f3_q),
        .ext_data (ext_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_be_o      <= '0;
            mem_wdata_o   <= '0;
            memory_data_o <= '0;
            done_o        <= 1'b0;
            f3_q          <= '0;
            off_q         <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    mem_req_o   <= 1'b1;
                    mem_we_o    <= memwren_i;
                    mem_addr_o  <= {addr_i[AWIDTH-1:2], 2'b00};
                    mem_be_o    <= be_nxt;
                    mem_wdata_o <= wdata_nxt;
                    f3_q        <= funct3_i;
                    off_q       <= addr_i[1:0];
                    state       <= REQ;
                end
                REQ: if (mem_gnt_i) begin
                    mem_req_o <= 1'b0;
                    done_o    <= mem_we_o;
                    state     <= mem_we_o ? DONE : WAIT;
                end
                WAIT: if (mem_rvalid_i) begin
                    memory_data_o <= ext_data;
                    done_o        <= 1'b1;
                    state         <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data width; AWIDTH, default 32, address width.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports valid_i in 1 instruction valid; memren_i in 1 load; memwren_i in 1 store; funct3_i in 3 access size/sign.
REQ-005 SHALL have ports addr_i in AWIDTH effective address (ALU result); store_data_i in DWIDTH rs2 value.
REQ-006 SHALL have ports stall_o out 1 hold pipeline; done_o out 1 access complete; err_o out 1 misaligned/illegal access.
REQ-007 SHALL have port memory_data_o out DWIDTH, the extended load data consumed by writeback.
REQ-008 SHALL have data-memory ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out AWIDTH (word aligned), mem_be_o out 4, mem_wdata_o out DWIDTH, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in DWIDTH.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-010 IDLE: access = valid_i & (memren_i ^ memwren_i); legal access -> capture addr, funct3, byte offset, we, be, wdata into registers; go to REQ.
REQ-011 Illegal in IDLE: half with addr_i[0]=1, word with addr_i[1:0]!=0, load funct3 in {3,6,7}, store funct3 >2, or memren_i & memwren_i both high -> err_o=1 that cycle, no request, stay IDLE, stall_o=0.
REQ-012 stall_o SHALL be 1 in IDLE on a legal access (combinational), in REQ and in WAIT; 0 in DONE and otherwise.
REQ-013 REQ: mem_req_o=1, address/be/we/wdata driven from captured registers and held stable until mem_gnt_i=1; on grant, store -> DONE, load -> WAIT.
REQ-014 WAIT: mem_req_o=0; on mem_rvalid_i=1, register extended data into memory_data_o; go to DONE.
REQ-015 DONE: done_o=1 for exactly one cycle; go to IDLE; new access accepted only from IDLE (next cycle).
REQ-016 mem_addr_o SHALL be {captured addr[AWIDTH-1:2], 2'b00}.
REQ-017 Store lanes: SB be=4'b0001<<off, wdata = byte replicated x4; SH be=4'b0011<<off, wdata = half replicated x2; SW be=4'b1111, wdata unchanged.
REQ-018 Load extract: select byte/half at offset; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged to DWIDTH.
REQ-019 memory_data_o SHALL hold its value until the next load completes; stores do not modify it.
REQ-020 mem_rvalid_i in IDLE, REQ or DONE SHALL be ignored; mem_gnt_i outside REQ SHALL be ignored.
REQ-021 Minimum load latency: accept cycle N, grant N+1, rvalid N+2, done_o N+3; arbitrary gnt/rvalid wait states SHALL be tolerated with no timeout.

Reset
REQ-022 Reset assertion SHALL asynchronously force IDLE; mem_req_o, mem_we_o, done_o, stall_o (registered component), err_o = 0; mem_be_o=0; memory_data_o, mem_addr_o, mem_wdata_o = 0.
REQ-023 Reset mid-access (REQ/WAIT) SHALL abandon the access; a late mem_rvalid_i after release SHALL be ignored and not update memory_data_o.

Structure
REQ-024 FSM state enum and funct3 size constants (LB, LH, LW, LBU, LHU, SB, SH, SW) SHALL live in the shared project package.
REQ-025 Load extraction SHALL be one combinational sub-module, load_extend (inputs rdata, offset, funct3; output extended data).

Verification
REQ-026 LW addr 0x100, gnt at once, rvalid next cycle, rdata 0xDEADBEEF -> mem_addr_o 0x100, be 4'b1111, done_o at N+3, memory_data_o 0xDEADBEEF.
REQ-027 LB addr 0x103, rdata 0x80FF_0000 -> memory_data_o 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
REQ-028 SH addr 0x202, store_data 0x1234ABCD, gnt delayed 3 cycles -> req/addr 0x200/be 4'b1100/wdata 0xABCDABCD stable all 4 REQ cycles, we=1, done_o one cycle after grant, memory_data_o unchanged.
REQ-029 LW addr 0x101 -> err_o=1 one cycle, mem_req_o stays 0, stall_o 0; same for memren_i=memwren_i=1.
REQ-030 Reset asserted during WAIT, released, then stray rvalid with 0x55555555 -> state IDLE, memory_data_o 0, done_o never pulses.
